// File: rtl/rsa_modexp.sv
// rsa_modexp: base^exponent mod modulus by binary square-and-multiply.
// The modular multiplier is an interleaved MSB-first shift-add-subtract
// core that consumes one multiplier bit per clock.
// Optional feature macro: RSA_CONST_TIME_EN, which processes every exponent
// bit so that latency does not depend on the exponent.
module rsa_modexp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] base,
  input  logic [2*WIDTH-1:0] exponent,
  input  logic [2*WIDTH-1:0] modulus,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned OW = 2 * WIDTH;
  localparam int unsigned AW = OW + 2;
  localparam int unsigned CW = $clog2(OW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_CHECK,
    S_MULT,
    S_SQUARE,
    S_HOLD
  } state_t;

  state_t        state, state_next;
  logic [OW-1:0] base_q, n_q, rem, b, r;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          last;
  logic [OW-1:0] mx, my;
  logic [AW-1:0] t_dbl, t_red1, t_add, mm_out;
  logic [OW-1:0] res_next;
`ifdef RSA_CONST_TIME_EN
  logic [CW-1:0] bits;
`endif

  assign last = (cnt == CW'(0));

  // One shift-add-subtract step of modmul(mx, my) on the shared accumulator
  always_comb begin
    mx = '0;
    my = '0;
    case (state)
      S_REDUCE: begin mx = OW'(1); my = base_q; end
      S_MULT:   begin mx = r;      my = b;      end
      S_SQUARE: begin mx = b;      my = b;      end
      default:  ;
    endcase
    t_dbl  = acc << 1;
    t_red1 = (t_dbl >= AW'(n_q)) ? t_dbl - AW'(n_q) : t_dbl;
    t_add  = t_red1 + (my[cnt] ? AW'(mx) : AW'(0));
    mm_out = (t_add >= AW'(n_q)) ? t_add - AW'(n_q) : t_add;
  end

  // Next-state and next-result selection
  always_comb begin
    state_next = state;
    res_next   = result;
    case (state)
      S_IDLE, S_HOLD: if (start) state_next = S_REDUCE;
      S_REDUCE: begin
        if (n_q < OW'(2)) state_next = S_HOLD;
        else if (last)    state_next = S_CHECK;
      end
      S_CHECK: begin
`ifdef RSA_CONST_TIME_EN
        state_next = S_MULT;
`else
        if (rem == '0)   state_next = S_HOLD;
        else if (rem[0]) state_next = S_MULT;
        else             state_next = S_SQUARE;
`endif
      end
      S_MULT: begin
        if (last) begin
`ifdef RSA_CONST_TIME_EN
          state_next = S_SQUARE;
`else
          state_next = (rem[OW-1:1] == '0) ? S_HOLD : S_SQUARE;
`endif
        end
      end
      S_SQUARE: begin
        if (last) begin
`ifdef RSA_CONST_TIME_EN
          state_next = (bits == CW'(OW - 1)) ? S_HOLD : S_CHECK;
`else
          state_next = S_CHECK;
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase
    // result is loaded only on the edge that enters HOLD
    if (state_next == S_HOLD && state != S_HOLD) begin
      if (state == S_REDUCE)    res_next = '0;
      else if (state == S_MULT) res_next = mm_out[OW-1:0];
      else                      res_next = r;
    end
  end

  // State, status outputs and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      base_q <= '0;
      n_q    <= '0;
      rem    <= '0;
      b      <= '0;
      r      <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef RSA_CONST_TIME_EN
      bits   <= '0;
`endif
    end else begin
      state  <= state_next;
      busy   <= (state_next != S_IDLE) && (state_next != S_HOLD);
      done   <= (state_next == S_HOLD);
      result <= res_next;
      case (state)
        S_IDLE, S_HOLD: begin
          if (start) begin
            base_q <= base;
            n_q    <= modulus;
            rem    <= exponent;
            r      <= OW'(1);
            b      <= '0;
            acc    <= '0;
            cnt    <= CW'(OW - 1);
`ifdef RSA_CONST_TIME_EN
            bits   <= '0;
`endif
          end
        end
        S_REDUCE, S_MULT, S_SQUARE: begin
          acc <= last ? '0 : mm_out;
          cnt <= last ? CW'(OW - 1) : cnt - CW'(1);
          if (last) begin
            case (state)
              S_REDUCE: b <= mm_out[OW-1:0];
              S_MULT: begin
`ifdef RSA_CONST_TIME_EN
                // product is always formed; kept only for a set exponent bit
                if (rem[0]) r <= mm_out[OW-1:0];
`else
                r <= mm_out[OW-1:0];
`endif
              end
              S_SQUARE: begin
                b   <= mm_out[OW-1:0];
                rem <= rem >> 1;
`ifdef RSA_CONST_TIME_EN
                bits <= bits + CW'(1);
`endif
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp: table vectors, random operands against an arithmetic
// reference model, and control corner cases. Honours RSA_CONST_TIME_EN.
module tb_rsa_modexp;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OW    = 2 * WIDTH;
  localparam int          LIMIT = 9000;
`ifdef RSA_CONST_TIME_EN
  localparam int          NRAND = 1;
`else
  localparam int          NRAND = 4;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [OW-1:0] base, exponent, modulus;
  logic          busy, done;
  logic [OW-1:0] result;

  int nvec = 0;
  int nerr = 0;

  rsa_modexp #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base(base), .exponent(exponent), .modulus(modulus),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] b;
    logic [OW-1:0] e;
    logic [OW-1:0] n;
    logic [OW-1:0] res;
    int            lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] mulmod(input logic [OW-1:0] a, input logic [OW-1:0] c,
                                           input logic [OW-1:0] n);
    logic [2*OW-1:0] p;
    p = {{OW{1'b0}}, a} * {{OW{1'b0}}, c};
    return OW'(p % {{OW{1'b0}}, n});
  endfunction

  // Right-to-left square-and-multiply in plain wide arithmetic
  function automatic logic [OW-1:0] ref_modexp(input logic [OW-1:0] bb, input logic [OW-1:0] e,
                                               input logic [OW-1:0] n);
    logic [OW-1:0] acc_r, sq;
    if (n < OW'(2)) return '0;
    acc_r = OW'(1);
    sq    = bb % n;
    for (int i = 0; i < int'(OW); i++) begin
      if (e[i]) acc_r = mulmod(acc_r, sq, n);
      sq = mulmod(sq, sq, n);
    end
    return acc_r;
  endfunction

  function automatic int ref_lat(input logic [OW-1:0] e, input logic [OW-1:0] n);
    int bl, pc;
    if (n < OW'(2)) return 2;
`ifdef RSA_CONST_TIME_EN
    return 1 + int'(OW) + int'(OW) * (1 + 2 * int'(OW));
`else
    if (e == '0) return 2 + int'(OW);
    bl = 0;
    pc = 0;
    for (int i = 0; i < int'(OW); i++) begin
      if (e[i]) begin
        bl = i + 1;
        pc++;
      end
    end
    return 1 + int'(OW) + bl + int'(OW) * pc + int'(OW) * (bl - 1);
`endif
  endfunction

  logic [OW-1:0] prev_res;

  // One full operation; optionally re-pulses start at cycle poke_at
  task automatic run(input string tag, input logic [OW-1:0] vb, input logic [OW-1:0] ve,
                     input logic [OW-1:0] vn, input logic [OW-1:0] want, input int want_lat,
                     input int poke_at);
    int lat, bcyc;
    @(negedge clk);
    base = vb; exponent = ve; modulus = vn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = {$urandom, $urandom}; exponent = {$urandom, $urandom}; modulus = {$urandom, $urandom};
    lat = 1;
    bcyc = 0;
    if (want_lat > 1) begin
      chk({tag, " done_drop"}, OW'(done), OW'(0));
      chk({tag, " result_hold"}, result, prev_res);
    end
    while (!done && lat < LIMIT) begin
      if (busy) bcyc++;
      start = (lat == poke_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, OW'(lat), OW'(want_lat));
    chk({tag, " busy_cycles"}, OW'(bcyc), OW'(want_lat - 1));
    chk({tag, " result"}, result, want);
    chk({tag, " busy_in_hold"}, OW'(busy), OW'(0));
    prev_res = result;
  endtask

  initial begin
    logic [OW-1:0] rb, re, rn, p1, p2;
    int ct_lat;
    ct_lat = 1 + int'(OW) + int'(OW) * (1 + 2 * int'(OW));
    tbl[0] = '{OW'(65),   OW'(17),   OW'(3233), OW'(2790), 454};
    tbl[1] = '{OW'(2790), OW'(2753), OW'(3233), OW'(65),   1101};
    tbl[2] = '{OW'(3298), OW'(17),   OW'(3233), OW'(2790), 454};
    tbl[3] = '{OW'(4),    OW'(13),   OW'(497),  OW'(445),  453};
    tbl[4] = '{OW'(1234), OW'(0),    OW'(3233), OW'(1),    66};
    tbl[5] = '{OW'(77),   OW'(5),    OW'(1),    OW'(0),    2};
    tbl[6] = '{OW'(77),   OW'(5),    OW'(0),    OW'(0),    2};
`ifdef RSA_CONST_TIME_EN
    for (int i = 0; i < 7; i++) if (tbl[i].n >= OW'(2)) tbl[i].lat = ct_lat;
`endif

    reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", OW'(busy), OW'(0));
    chk("rst done", OW'(done), OW'(0));
    chk("rst result", result, OW'(0));
    reset = 1'b0;
    prev_res = '0;

    // first vector also re-pulses start while busy; later ones start from HOLD
    for (int i = 0; i < 7; i++)
      run($sformatf("vec%0d", i), tbl[i].b, tbl[i].e, tbl[i].n, tbl[i].res, tbl[i].lat,
          (i == 0) ? 100 : -1);

    p1 = OW'(64'd4294967291);
    p2 = OW'(64'd4294967279);
    for (int k = 0; k < NRAND; k++) begin
      rb = {$urandom, $urandom};
      re = {$urandom, $urandom};
      rn = (k == 0) ? p1 * p2 : ({$urandom, $urandom} | {1'b1, {(OW - 2){1'b0}}, 1'b1});
      run($sformatf("rand%0d", k), rb, re, rn, ref_modexp(rb, re, rn), ref_lat(re, rn), -1);
    end

    // reset during the first MULT aborts immediately
    @(negedge clk);
    base = OW'(65); exponent = OW'(17); modulus = OW'(3233); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    chk("mid busy", OW'(busy), OW'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", OW'(busy), OW'(0));
    chk("abort done", OW'(done), OW'(0));
    chk("abort result", result, OW'(0));
    prev_res = '0;
    run("after_abort", OW'(4), OW'(13), OW'(497), OW'(445),
        ref_lat(OW'(13), OW'(497)), -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rsa_modexp.md
Name: rsa_modexp

Overview:
- Modular exponentiation engine. Computes result = base^exponent mod modulus by binary square-and-multiply.
- It is the consumer of the key-generation block. Encryption feeds it (m, e, n = p*q). Decryption feeds it (c, d, n).
- Modular multiplication is an interleaved MSB-first shift-add-subtract, one multiplier bit per clock. There is no hardware multiplier or divider.
- Operand width is 2*WIDTH, which matches the key outputs of the generator.

Parameters:
WIDTH, 32, prime width in bits; all operands and the result are 2*WIDTH bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or HOLD
base  input  2*WIDTH  message or ciphertext; any value, including base >= modulus
exponent  input  2*WIDTH  e or d
modulus  input  2*WIDTH  n
busy  output  1  high from the cycle after start is accepted until the cycle before HOLD is entered
done  output  1  high while in HOLD; result is valid
result  output  2*WIDTH  base^exponent mod modulus

Behaviour:
- Reset: clk and reset as listed above (synchronous, active-high). On reset, state goes to IDLE and busy=0, done=0, result=0.
- Reset mid-operation aborts the operation immediately with the same values. Reset has priority over start.
- Operand capture: start=1 in IDLE or HOLD latches base, exponent and modulus on the same edge. done drops and busy rises on that edge. start while busy is ignored, and the latched operands are never re-read.
- Degenerate modulus: if the latched modulus < 2, go directly to HOLD on the next edge with result=0. Latency is 2 edges.
- Modmul(x, y) core:
  - Accumulator is 2*WIDTH+2 bits, acc starts at 0.
  - Runs exactly 2*WIDTH cycles, bit i = 2*WIDTH-1 down to 0.
  - Each cycle: acc = 2*acc; if acc >= n then acc -= n; if y[i] then acc += x; if acc >= n then acc -= n.
  - Requires x < n. Output is always < n.
- States:
  - IDLE: wait for start.
  - REDUCE: b = modmul(1, base), which gives base mod n. rem = exponent. r = 1. Lasts 2*WIDTH cycles, then goes to CHECK.
  - CHECK (1 cycle): if rem == 0 go to HOLD; else if rem[0] go to MULT; else go to SQUARE.
  - MULT (2*WIDTH cycles): r = modmul(r, b). Then go to HOLD if (rem>>1) == 0, otherwise go to SQUARE.
  - SQUARE (2*WIDTH cycles): b = modmul(b, b). On exit, rem = rem>>1, then go to CHECK.
  - HOLD: result = r, done=1. Holds indefinitely; start re-arms the engine.
- result changes only on entry to HOLD, or on reset. It keeps its previous value while busy.
- Latency L, in edges from the start-sampling edge to done high:
  - L = 1 + 2W + bitlen(e) + 2W*popcount(e) + 2W*(bitlen(e)-1), with W = WIDTH.
  - For e = 0: L = 2 + 2W.
- Inputs may change freely after acceptance.

Optional Feature:
- Macro: RSA_CONST_TIME_EN.
- Defined:
  - Every one of the 2*WIDTH exponent bits is processed and the zero test is removed.
  - CHECK always enters MULT. When rem[0] = 0 the MULT output is computed but discarded; r is unchanged.
  - Every MULT is followed by SQUARE, including the final one.
  - L = 1 + 2W + 2W*(1 + 4W), independent of exponent and base (8321 for WIDTH=32).
  - The modulus < 2 path is unchanged.
- Not defined: data-dependent latency as given in Behaviour.

Test Plan:
- WIDTH=32; base=65, exponent=17, modulus=3233 -> result=2790, done at L=1+64+5+128+256=454; busy high for exactly L-1 cycles.
- base=2790, exponent=2753, modulus=3233 -> result=65.
- base=3298 (>= n), exponent=17, modulus=3233 -> result=2790.
- base=4, exponent=13, modulus=497 -> result=445 at L=453.
- Edge cases:
  - exponent=0, modulus=3233 -> result=1, L=66.
  - modulus=1 -> result=0, L=2.
  - Random 64-bit base and exponent with modulus = product of two 32-bit primes -> matches reference model.
- Control:
  - start pulsed again while busy -> ignored, original result delivered.
  - reset asserted mid-MULT -> next cycle busy=0, done=0, result=0.
  - New start from HOLD -> done drops on the accept edge.
  - With RSA_CONST_TIME_EN: all cases give identical results with L=8321.
